// File: rtl/rvc_asap_5pl_dmem_arb.sv
// rvc_asap_5pl_dmem_arb
//   Arbitrates the single data-memory port between the 5-stage core and one
//   external master (debug loader / DMA). The core owns the port by default.
//   The external master is granted in the same cycle through a req/gnt
//   handshake. Read data is routed back after a fixed memory read latency.
//
//   Handshake: the external master holds ExtReq (with ExtWe/ExtAddress/
//   ExtData/ExtByteena stable) until it sees ExtGnt=1 in a cycle; that cycle
//   the access is issued to memory. Writes complete at grant. Reads return
//   on ExtRdValid exactly RD_LATENCY cycles after the grant. The core has no
//   grant; CoreStall=1 means its request was not issued this cycle and must
//   be held.
//
// Parameters
//   RD_LATENCY  cycles from MemRden to valid MemQ (>=1)
//   MAX_WAIT    external starvation limit in cycles (starvation guard only)
//
// Optional feature
//   DMEM_ARB_STARVE_GUARD_EN  when defined, an external request that has
//   waited MAX_WAIT cycles is forced through, stalling the core one cycle.
//   When undefined the core has strict priority.
//
// Ports
//   Clock, Rst                          clock, synchronous active-high reset
//   Core*  (Data/Address/Byteena/Wren/Rden in, Q/Stall out)  core side
//   Ext*   (Req/We/Address/Data/Byteena in, Gnt/RdValid/RdData out)  ext side
//   Mem*   (Data/Address/Byteena/Wren/Rden out, Q in)  to D_MEM
//   ArbState  registered owner of the previous cycle (IDLE/CORE/EXT/FORCE)

module rvc_asap_5pl_dmem_arb #(
   parameter int RD_LATENCY = 1,
   parameter int MAX_WAIT   = 8
) (
   input  logic        Clock,
   input  logic        Rst,
   input  logic [31:0] CoreData,
   input  logic [31:0] CoreAddress,
   input  logic [3:0]  CoreByteena,
   input  logic        CoreWren,
   input  logic        CoreRden,
   output logic [31:0] CoreQ,
   output logic        CoreStall,
   input  logic        ExtReq,
   input  logic        ExtWe,
   input  logic [31:0] ExtAddress,
   input  logic [31:0] ExtData,
   input  logic [3:0]  ExtByteena,
   output logic        ExtGnt,
   output logic        ExtRdValid,
   output logic [31:0] ExtRdData,
   output logic [31:0] MemData,
   output logic [31:0] MemAddress,
   output logic [3:0]  MemByteena,
   output logic        MemWren,
   output logic        MemRden,
   input  logic [31:0] MemQ,
   output logic [1:0]  ArbState
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CORE  = 2'd1,
      ST_EXT   = 2'd2,
      ST_FORCE = 2'd3
   } arb_state_t;

   arb_state_t state, state_nxt;

   logic core_req, ext_req, force_ext, ext_gnt, core_gnt;

   // Requests are masked during reset so every output derived from them is 0.
   assign core_req = (CoreWren | CoreRden) & ~Rst;
   assign ext_req  = ExtReq & ~Rst;
   assign ext_gnt  = ext_req & (~core_req | force_ext);
   assign core_gnt = core_req & ~ext_gnt;

   assign ExtGnt    = ext_gnt;
   assign CoreStall = core_req & ext_gnt;

   // ---------------- starvation guard ----------------
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] wait_cnt;
   logic          force_q;

   // force_q is registered: once the count has reached MAX_WAIT, the
   // external master is granted in the following cycle.
   always_ff @(posedge Clock) begin
      if (Rst) begin
         wait_cnt <= '0;
         force_q  <= 1'b0;
      end else if (!ext_req || ext_gnt) begin
         wait_cnt <= '0;
         force_q  <= 1'b0;
      end else begin
         force_q <= (wait_cnt == CW'(MAX_WAIT));
         if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end
   end
   assign force_ext = force_q;
`else
   logic unused_max_wait;
   assign unused_max_wait = ^MAX_WAIT;
   assign force_ext       = 1'b0;
`endif

   // ---------------- owner FSM ----------------
   always_ff @(posedge Clock) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_IDLE;
      if (ext_gnt)       state_nxt = (force_ext & core_req) ? ST_FORCE : ST_EXT;
      else if (core_gnt) state_nxt = ST_CORE;
   end

   assign ArbState = state;

   // ---------------- memory port mux ----------------
   always_comb begin
      MemData    = '0;
      MemAddress = '0;
      MemByteena = '0;
      MemWren    = 1'b0;
      MemRden    = 1'b0;
      if (ext_gnt) begin
         MemData    = ExtData;
         MemAddress = ExtAddress;
         MemByteena = ExtByteena;
         MemWren    = ExtWe;
         MemRden    = ~ExtWe;
      end else if (core_gnt) begin
         MemData    = CoreData;
         MemAddress = CoreAddress;
         MemByteena = CoreByteena;
         MemWren    = CoreWren;
         MemRden    = CoreRden;
      end
   end

   // ---------------- read tag pipe ----------------
   // One {valid, owner_is_ext} tag per issued cycle; the tag leaving the
   // last stage lines up with the MemQ word of that read.
   logic [RD_LATENCY-1:0] tag_vld, tag_ext, tag_vld_nxt, tag_ext_nxt;

   generate
      if (RD_LATENCY > 1) begin : g_shift
         assign tag_vld_nxt = {tag_vld[RD_LATENCY-2:0], MemRden};
         assign tag_ext_nxt = {tag_ext[RD_LATENCY-2:0], ext_gnt};
      end else begin : g_single
         assign tag_vld_nxt = MemRden;
         assign tag_ext_nxt = ext_gnt;
      end
   endgenerate

   always_ff @(posedge Clock) begin
      if (Rst) begin
         tag_vld <= '0;
         tag_ext <= '0;
      end else begin
         tag_vld <= tag_vld_nxt;
         tag_ext <= tag_ext_nxt;
      end
   end

   assign ExtRdValid = ~Rst & tag_vld[RD_LATENCY-1] & tag_ext[RD_LATENCY-1];
   assign ExtRdData  = ExtRdValid ? MemQ : '0;
   // The core pipeline tracks its own read timing; it just sees MemQ.
   assign CoreQ      = Rst ? '0 : MemQ;

endmodule
